// File: rtl/gate_mux_sequencer.sv
// gate_mux_sequencer: sweeps all 32 {sel,b,a} vectors through an external
// gate-select datapath and counts results that differ from the expected
// gate function. Each vector is held for DWELL cycles and then sampled.
// Optional feature macro: GATE_SEQ_STEP_EN adds step mode (WAIT_STEP state,
// step/step_mode inputs). When it is undefined, those inputs are ignored and
// the block always free-runs.
module gate_mux_sequencer #(
    parameter int unsigned DWELL = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       step,
    input  logic       step_mode,
    input  logic       mux_out,
    output logic [2:0] sel,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic [5:0] err_cnt,
    output logic [4:0] first_err
);

    localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        FIN
`ifdef GATE_SEQ_STEP_EN
        , WAIT_STEP
`endif
    } state_t;

    state_t      state;
    logic [4:0]  idx;
    logic [4:0]  next_idx;
    logic [15:0] dwell_cnt;
    logic        expected;

`ifndef GATE_SEQ_STEP_EN
    logic unused_step_inputs;
    assign unused_step_inputs = step | step_mode;
`endif

    assign next_idx = idx + 5'd1;

    // Expected gate result for the vector currently being driven
    always_comb begin
        expected = 1'b0;
        case (idx[4:2])
            3'd0: expected = ~(idx[1] & idx[0]);
            3'd1: expected =   idx[1] & idx[0];
            3'd2: expected = ~(idx[1] | idx[0]);
            3'd3: expected =   idx[1] | idx[0];
            3'd4: expected =   idx[1] ^ idx[0];
            3'd5: expected = ~(idx[1] ^ idx[0]);
            3'd6: expected =   idx[0];
            3'd7: expected =  ~idx[0];
            default: expected = 1'b0;
        endcase
    end

    // Sweep sequencer FSM; sel/b/a always mirror idx and are updated with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            dwell_cnt <= '0;
            sel       <= '0;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_cnt   <= '0;
            first_err <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx       <= '0;
                        sel       <= '0;
                        a         <= 1'b0;
                        b         <= 1'b0;
                        dwell_cnt <= '0;
                        err_cnt   <= '0;
                        first_err <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        state     <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (dwell_cnt == DWELL_LAST) begin
                        dwell_cnt <= '0;
                        state     <= SAMPLE;
                    end else begin
                        dwell_cnt <= dwell_cnt + 16'd1;
                    end
                end
                SAMPLE: begin
                    if (mux_out != expected) begin
                        if (err_cnt != 6'd32) begin
                            err_cnt <= err_cnt + 6'd1;
                        end
                        if (err_cnt == 6'd0) begin
                            first_err <= idx;
                        end
                    end
                    if (idx == 5'd31) begin
                        state <= FIN;
`ifdef GATE_SEQ_STEP_EN
                    end else if (step_mode) begin
                        state <= WAIT_STEP;
`endif
                    end else begin
                        idx           <= next_idx;
                        {sel, b, a}   <= next_idx;
                        state         <= DRIVE;
                    end
                end
`ifdef GATE_SEQ_STEP_EN
                WAIT_STEP: begin
                    // Dropping step_mode releases the sweep like a step pulse
                    if (step || !step_mode) begin
                        idx         <= next_idx;
                        {sel, b, a} <= next_idx;
                        state       <= DRIVE;
                    end
                end
`endif
                FIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
